ssr_select: RTL and testbench

SSR_SELECT -- requirements
Module: ssr_select

---
 rtl/ssr_sel_pkg.sv | 28 ++
 rtl/ssr_acc.sv | 28 ++
 rtl/ssr_select.sv | 145 ++++++++++++++
 tb/tb_ssr_select.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssr_sel_pkg.sv
// ssr_sel_pkg: shared FSM encoding and width helpers for the SSR antenna selector.
package ssr_sel_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPARE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Accumulator width: one complex SSR word plus headroom for acc_len beats.
  function automatic int calc_acc_w(input int data_width, input int acc_len);
    return 2 * data_width + clog2(acc_len);
  endfunction

  // Antenna index width, at least one bit even for a single antenna.
  function automatic int calc_idx_w(input int antena_num);
    return (antena_num > 1) ? clog2(antena_num) : 1;
  endfunction

endpackage

// File: rtl/ssr_acc.sv
// ssr_acc: one antenna's SSR accumulator with synchronous clear.
module ssr_acc
  import ssr_sel_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int ACC_W = calc_acc_w(32, 16)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             add_en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_reg;

  // Clear has priority; otherwise add the zero-extended input when enabled.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_reg <= '0;
    end else if (add_en) begin
      acc_reg <= acc_reg + ACC_W'(din);
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/ssr_select.sv
// ssr_select: accumulates per-antenna SSR over a frame, then picks the antenna
// with the largest sum (lowest index wins ties).
// Optional macro SSR_SELECT_TLAST_EN adds s_ssr_tlast to end a frame early.
module ssr_select
  import ssr_sel_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ANTENA_NUM = 4,
  parameter int  ACC_LEN    = 16,
  localparam int ACC_W      = calc_acc_w(DATA_WIDTH, ACC_LEN),
  localparam int IDX_W      = calc_idx_w(ANTENA_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*ANTENA_NUM*DATA_WIDTH-1:0] s_ssr_tdata,
`ifdef SSR_SELECT_TLAST_EN
  input  logic                              s_ssr_tlast,
`endif
  input  logic                              s_ssr_tvalid,
  output logic                              s_ssr_tready,
  output logic [IDX_W-1:0]                  m_sel_idx,
  output logic [ACC_W-1:0]                  m_sel_power,
  output logic                              m_sel_valid,
  input  logic                              m_sel_ready
);

  localparam int SSR_W = 2 * DATA_WIDTH;
  localparam int CNT_W = clog2(ACC_LEN);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [IDX_W-1:0] cmp_cnt_reg, cmp_cnt_next;
  logic [IDX_W-1:0] best_idx_reg, best_idx_next;
  logic [ACC_W-1:0] best_power_reg, best_power_next;
  logic             valid_reg, valid_next;

  logic             accept;
  logic             frame_last;
  logic             acc_clr;
  logic             acc_add;
  logic [ACC_W-1:0] acc_q [ANTENA_NUM];
  logic [ACC_W-1:0] cur_acc;

  // Ready is gated by rst so it reads 0 for the whole reset period.
  assign s_ssr_tready = (state_reg == ST_ACCUM) && !rst;
  assign accept       = s_ssr_tvalid && s_ssr_tready;

`ifdef SSR_SELECT_TLAST_EN
  assign frame_last = s_ssr_tlast;
`else
  assign frame_last = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < ANTENA_NUM; gi++) begin : g_acc
      ssr_acc #(
        .IN_W  (SSR_W),
        .ACC_W (ACC_W)
      ) u_acc (
        .clk    (clk),
        .clr    (acc_clr),
        .add_en (acc_add),
        .din    (s_ssr_tdata[SSR_W*gi +: SSR_W]),
        .acc    (acc_q[gi])
      );
    end
  endgenerate

  assign cur_acc = acc_q[cmp_cnt_reg];

  // State, counters and selection result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_ACCUM;
      beat_cnt_reg   <= '0;
      cmp_cnt_reg    <= '0;
      best_idx_reg   <= '0;
      best_power_reg <= '0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      cmp_cnt_reg    <= cmp_cnt_next;
      best_idx_reg   <= best_idx_next;
      best_power_reg <= best_power_next;
      valid_reg      <= valid_next;
    end
  end

  // Next-state logic: accumulate a frame, scan antennas one per cycle, hold result.
  always_comb begin
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    cmp_cnt_next    = cmp_cnt_reg;
    best_idx_next   = best_idx_reg;
    best_power_next = best_power_reg;
    valid_next      = valid_reg;
    acc_clr         = rst;
    acc_add         = 1'b0;
    case (state_reg)
      ST_ACCUM: begin
        if (accept) begin
          acc_add = 1'b1;
          if (beat_cnt_reg == CNT_W'(ACC_LEN - 1) || frame_last) begin
            beat_cnt_next = '0;
            cmp_cnt_next  = '0;
            state_next    = ST_COMPARE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        // Antenna 0 seeds the search; later ones must be strictly larger.
        if (cmp_cnt_reg == '0 || cur_acc > best_power_reg) begin
          best_idx_next   = cmp_cnt_reg;
          best_power_next = cur_acc;
        end
        if (cmp_cnt_reg == IDX_W'(ANTENA_NUM - 1)) begin
          cmp_cnt_next = '0;
          state_next   = ST_HOLD;
        end else begin
          cmp_cnt_next = cmp_cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!valid_reg) begin
          valid_next = 1'b1;
        end else if (m_sel_ready) begin
          valid_next = 1'b0;
          acc_clr    = 1'b1;
          state_next = ST_ACCUM;
        end
      end
      default: begin
        state_next = ST_ACCUM;
      end
    endcase
  end

  assign m_sel_idx   = best_idx_reg;
  assign m_sel_power = best_power_reg;
  assign m_sel_valid = valid_reg;

endmodule

// File: tb/tb_ssr_select.sv
// tb_ssr_select: directed plus randomized frames checked against a sum/argmax model.
module tb_ssr_select;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int SW = 2 * DW;
  localparam int AW = 2 * DW + 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*SW-1:0]   s_ssr_tdata;
  logic              s_ssr_tlast;
  logic              s_ssr_tvalid;
  logic              s_ssr_tready;
  logic [IW-1:0]     m_sel_idx;
  logic [AW-1:0]     m_sel_power;
  logic              m_sel_valid;
  logic              m_sel_ready;

  int checks   = 0;
  int failures = 0;
  int gap_max  = 0;
  logic [SW-1:0] beats [L][N];

  always #5 clk = ~clk;

  ssr_select #(
    .DATA_WIDTH (DW),
    .ANTENA_NUM (N),
    .ACC_LEN    (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_ssr_tdata  (s_ssr_tdata),
`ifdef SSR_SELECT_TLAST_EN
    .s_ssr_tlast  (s_ssr_tlast),
`endif
    .s_ssr_tvalid (s_ssr_tvalid),
    .s_ssr_tready (s_ssr_tready),
    .m_sel_idx    (m_sel_idx),
    .m_sel_power  (m_sel_power),
    .m_sel_valid  (m_sel_valid),
    .m_sel_ready  (m_sel_ready)
  );

  task automatic chk(input string tag, input logic [AW-1:0] observed, input logic [AW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill the beat table: antenna 'ant' gets 'hot', all others 'cold' (ant<0: all cold).
  task automatic set_const(input int ant, input logic [SW-1:0] hot, input logic [SW-1:0] cold);
    for (int b = 0; b < L; b++)
      for (int k = 0; k < N; k++)
        beats[b][k] = (k == ant) ? hot : cold;
  endtask

  task automatic set_random();
    int mode;
    mode = $urandom_range(0, 2);
    for (int b = 0; b < L; b++)
      for (int k = 0; k < N; k++) begin
        if (mode == 0)      beats[b][k] = {$urandom(), $urandom()};
        else if (mode == 1) beats[b][k] = SW'($urandom_range(0, 3));
        else                beats[b][k] = SW'(b + 1);
      end
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send_beat(input int b, input logic last);
    int   n;
    logic ok;
    for (int k = 0; k < N; k++) s_ssr_tdata[k*SW +: SW] = beats[b][k];
    s_ssr_tvalid = 1'b1;
    s_ssr_tlast  = last;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ssr_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_ssr_tvalid = 1'b0;
    s_ssr_tlast  = 1'b0;
    chk("beat_accepted", AW'(ok), AW'(1));
  endtask

  // Send nb beats, check the selection against the model, optionally complete the handshake.
  task automatic do_frame(input int nb, input int hold, input bit use_last, input bit handshake);
    logic [AW-1:0] sums [N];
    logic [AW-1:0] best_p;
    int            best_i;
    int            n;
    for (int k = 0; k < N; k++) sums[k] = '0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < N; k++) sums[k] = sums[k] + AW'(beats[b][k]);
    best_i = 0;
    best_p = sums[0];
    for (int k = 1; k < N; k++)
      if (sums[k] > best_p) begin
        best_i = k;
        best_p = sums[k];
      end
    for (int b = 0; b < nb; b++) begin
      if (b > 0) repeat ($urandom_range(0, gap_max)) tick();
      send_beat(b, use_last && (b == nb - 1));
    end
    n = 0;
    while (!m_sel_valid && n < 50) begin
      tick();
      n++;
    end
    $display("frame beats=%0d idx=%0d power=%0h exp_idx=%0d exp_power=%0h latency=%0d",
             nb, m_sel_idx, m_sel_power, best_i, best_p, n);
    chk("latency", AW'(n), AW'(N + 1));
    chk("sel_idx", AW'(m_sel_idx), AW'(best_i));
    chk("sel_power", m_sel_power, best_p);
    if (handshake) begin
      for (int c = 0; c < hold; c++) begin
        tick();
        chk("hold_idx", AW'(m_sel_idx), AW'(best_i));
        chk("hold_power", m_sel_power, best_p);
        chk("hold_valid", AW'(m_sel_valid), AW'(1));
        chk("hold_tready", AW'(s_ssr_tready), AW'(0));
      end
      m_sel_ready = 1'b1;
      tick();
      m_sel_ready = 1'b0;
      chk("valid_clear", AW'(m_sel_valid), AW'(0));
      chk("tready_after_hs", AW'(s_ssr_tready), AW'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    s_ssr_tdata  = '0;
    s_ssr_tlast  = 1'b0;
    s_ssr_tvalid = 1'b0;
    m_sel_ready  = 1'b0;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_idx", AW'(m_sel_idx), AW'(0));
      chk("rst_power", m_sel_power, AW'(0));
      chk("rst_valid", AW'(m_sel_valid), AW'(0));
      chk("rst_tready", AW'(s_ssr_tready), AW'(0));
    end
    rst = 1'b0;
    #1;
    chk("tready_release", AW'(s_ssr_tready), AW'(1));

    // Antenna 2 dominant.
    set_const(2, SW'(10), SW'(1));
    do_frame(4, 0, 1'b0, 1'b1);

    // All equal: lowest index wins; ready withheld 10 cycles.
    set_const(-1, SW'(5), SW'(5));
    do_frame(4, 10, 1'b0, 1'b1);

    // Next frame must not carry over previous sums.
    set_const(3, SW'(7), SW'(0));
    do_frame(4, 0, 1'b0, 1'b1);

    // All-ones beats: maximum sum, exact in the accumulator width.
    set_const(-1, {SW{1'b1}}, {SW{1'b1}});
    do_frame(4, 2, 1'b0, 1'b1);

    // Reset after two beats of a frame, then a clean frame.
    set_random();
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    rst = 1'b1;
    tick();
    chk("midframe_rst_power", m_sel_power, AW'(0));
    chk("midframe_rst_valid", AW'(m_sel_valid), AW'(0));
    rst = 1'b0;
    set_const(1, SW'(3), SW'(0));
    do_frame(4, 0, 1'b0, 1'b1);

    // Reset during the compare phase.
    set_const(0, SW'(9), SW'(0));
    for (int b = 0; b < L; b++) send_beat(b, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("cmp_rst_valid", AW'(m_sel_valid), AW'(0));
    chk("cmp_rst_idx", AW'(m_sel_idx), AW'(0));
    chk("cmp_rst_power", m_sel_power, AW'(0));
    rst = 1'b0;

    // Reset while holding a result, then a frame with no carry-over.
    set_const(3, SW'(100), SW'(2));
    do_frame(4, 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("hold_rst_valid", AW'(m_sel_valid), AW'(0));
    rst = 1'b0;
    #1;
    chk("hold_rst_tready", AW'(s_ssr_tready), AW'(1));
    set_const(2, SW'(1), SW'(0));
    do_frame(4, 0, 1'b0, 1'b1);

`ifdef SSR_SELECT_TLAST_EN
    // tlast on the second beat closes a short frame.
    set_random();
    do_frame(2, 0, 1'b1, 1'b1);
`endif

    // Randomized frames with input gaps and downstream backpressure.
    gap_max = 2;
    for (int f = 0; f < 20; f++) begin
      set_random();
      do_frame(4, $urandom_range(0, 3), 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
